chan_sel_reg: RTL
=================

CHAN_SEL_REG -- requirements
Module: chan_sel_reg

Interface
REQ-001 Parameter WIDTH, default 4, data width per channel in bits (range 1..32).
REQ-002 Parameter NCH, default 4, number of input channels (range 2..16).
REQ-003 Localparam SELW = $clog2(NCH), width of channel index fields.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_data  input  NCH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  NCH  per-channel valid.
REQ-009 in_ready  output  NCH  per-channel ready; combinational.
REQ-010 mode  input  1  0 = manual select, 1 = round-robin.
REQ-011 sel  input  SELW  channel index used in manual mode.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_ch  output  SELW  registered index of the channel that supplied out_data.
REQ-014 out_valid  output  1  registered output valid.
REQ-015 out_ready  input  1  downstream ready.

Function
REQ-016 Transfer rule: a side transfers on a clock edge where its valid and ready are both 1.
REQ-017 load_en = !out_valid || out_ready.
REQ-018 At most one in_ready bit SHALL be 1, and only for the granted channel while load_en = 1.
REQ-019 Manual mode: grant = sel when in_valid[sel] = 1 and sel < NCH; otherwise no grant.
REQ-020 Round-robin mode: grant = first i with in_valid[i] = 1, searching ptr, ptr+1, ... with wrap modulo NCH.
REQ-021 ptr SHALL update to (granted index + 1) mod NCH after each round-robin input transfer.
REQ-022 ptr SHALL hold during manual mode.
REQ-023 On an input transfer, out_data, out_ch and out_valid SHALL load on that edge: 1-cycle latency, one item per cycle.
REQ-024 If out_ready = 1 and there is no input transfer, out_valid SHALL clear; out_data and out_ch SHALL hold.
REQ-025 If out_valid = 1 and out_ready = 0, all output registers SHALL hold, with all in_ready = 0.
REQ-026 mode and sel SHALL be sampled each cycle; a change SHALL affect only the next grant and never an item already held.
REQ-027 ptr wrap: from NCH-1, the next pointer value SHALL be 0.

Reset
REQ-028 While rst_n = 0 at a clock edge: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0.
REQ-029 While rst_n = 0, in_ready SHALL be all 0.
REQ-030 A reset asserted mid-stream SHALL discard any held item without completing a transfer.

Configuration
REQ-031 Macro CHAN_SEL_PARITY_EN SHALL control an optional parity output.
REQ-032 With CHAN_SEL_PARITY_EN defined: output out_par (1 bit) is registered alongside out_data; value = ^ of the loaded data (even parity); reset value 0.
REQ-033 Without CHAN_SEL_PARITY_EN: port out_par is absent and no parity logic exists.

Structure
REQ-034 Shared package chan_sel_pkg SHALL hold MODE_MANUAL = 1'b0, MODE_RR = 1'b1, and the default WIDTH and NCH.
REQ-035 Round-robin selection SHALL be a separate sub-module rr_arbiter (inputs req[NCH] and ptr; outputs gnt_vld and gnt_idx).
REQ-036 The datapath register and handshake logic SHALL stay in chan_sel_reg.

Verification
REQ-037 Reset: hold rst_n = 0 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 0.
REQ-038 Manual mode: sel = 2, in_valid = 4'b1111, ch2 = 4'hA, out_ready = 1 -> next cycle out_data = A, out_ch = 2, in_ready = 4'b0100.
REQ-039 Round-robin mode: in_valid = 4'b1111, out_ready = 1 for 5 cycles -> out_ch sequence 0, 1, 2, 3, 0 (wrap).
REQ-040 Round-robin skip: in_valid = 4'b1010 from ptr = 0 -> grants 1, 3, 1.
REQ-041 Backpressure: out_ready = 0 while out_valid = 1 for 3 cycles -> out_data stable, in_ready = 0, no pointer advance; then out_ready = 1 -> the next item loads in the same edge the held item drains.
REQ-042 Parity (macro defined): load 4'b0111 -> out_par = 1.
REQ-043 Reset in the middle of a round-robin stream: out_valid = 0 and ptr = 0; the first grant after release is channel 0.

Source files
------------

// File: rtl/chan_sel_pkg.sv
// Shared constants for the channel-select register slice: mode encodings and default sizing.
package chan_sel_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NCH   = 4;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/chan_sel_reg_rr_arbiter.sv
// Round-robin request picker: first asserted req at or after ptr, wrapping modulo NCH.
module rr_arbiter
    import chan_sel_pkg::*;
#(
    parameter  int NCH  = DEF_NCH,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] w_idx;

    // Scan farthest-first so the last hit written is the one nearest ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        w_idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = SELW'((int'(ptr) + k) % NCH);
            if (req[w_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/chan_sel_reg.sv
// Channel selector with a one-deep registered output stage; manual or round-robin grant.
// Optional even-parity output out_par is enabled by defining CHAN_SEL_PARITY_EN.
module chan_sel_reg
    import chan_sel_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NCH   = DEF_NCH,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef CHAN_SEL_PARITY_EN
    ,
    output logic                 out_par
`endif
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_load_en;
    logic             w_rr_vld;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_man_vld;
    logic             w_gnt_vld;
    logic [SELW-1:0]  w_gnt_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;
    logic [SELW-1:0]  w_ptr_nxt;

    rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt_vld (w_rr_vld),
        .gnt_idx (w_rr_idx)
    );

    assign w_load_en = !r_out_valid || out_ready;
    // The range check matters only when NCH is not a power of two.
    assign w_man_vld = (int'(sel) < NCH) && in_valid[sel];
    assign w_gnt_vld = (mode == MODE_RR) ? w_rr_vld : w_man_vld;
    assign w_gnt_idx = (mode == MODE_RR) ? w_rr_idx : sel;
    assign w_xfer    = rst_n && w_load_en && w_gnt_vld;
    assign w_sel_data = in_data[w_gnt_idx*WIDTH +: WIDTH];
    assign w_ptr_nxt  = SELW'(wrap_inc(int'(w_gnt_idx), NCH));

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_gnt_idx;
            r_out_valid <= 1'b1;
            if (mode == MODE_RR) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

`ifdef CHAN_SEL_PARITY_EN
    logic r_out_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_par <= 1'b0;
        end else if (w_xfer) begin
            r_out_par <= ^w_sel_data;
        end
    end

    assign out_par = r_out_par;
`endif

endmodule
